// File: rtl/qenc_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Phase is packed as {A,B}; the next-phase tables are indexed by the current phase.
package qenc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } qenc_state_e;

  // Entry i (bits [2i+1:2i]) is the phase that follows phase i.
  // CW walks 00->10->11->01->00; CCW walks the same ring backwards.
  localparam logic [7:0] CW_NEXT  = {2'b01, 2'b11, 2'b00, 2'b10};
  localparam logic [7:0] CCW_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

  localparam int unsigned PERIOD_MIN        = 1;
  localparam int unsigned BOUNCE_MIN_PERIOD = 4;

  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    logic [7:0] tbl;
    tbl = dir ? CW_NEXT : CCW_NEXT;
    return tbl[{ph, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/qenc_tick_div.sv
// Loadable down-counter that fires a one-cycle tick every period_i cycles.
// The load cycle itself counts as the first cycle, so period 1 ticks on the load.
module qenc_tick_div #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W-1:0] cnt_dec;
  logic                active;

  always_comb begin
    active  = load_i || en_i;
    cnt_dec = (load_i ? period_i : cnt_q) - ONE;
    tick_o  = active && (cnt_dec == '0);
    cnt_d   = cnt_q;
    if (tick_o) begin
      cnt_d = period_i;
    end else if (active) begin
      cnt_d = cnt_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_encoder_tx.sv
// Quadrature A/B emulator: emits cmd_steps Gray-coded edges, one every cmd_period cycles.
// Define QENC_BOUNCE_EN to build the optional one-cycle contact-bounce glitch on each edge.
module quadrature_encoder_tx
  import qenc_pkg::*;
#(
  parameter int STEP_W   = 8,
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_valid while busy is simply not taken.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                bounce_en,
  output logic                enc_a,
  output logic                enc_b,
  output logic                busy,
  output logic                done,
  output logic [POS_W-1:0]    position,
  output qenc_state_e         dbg_state_o
);

  qenc_state_e         state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                dir_q, dir_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                done_q, done_d;

  logic                accept;
  logic                load;
  logic                tick;
  logic                cur_dir;
  logic [STEP_W-1:0]   cur_rem;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] div_period;

  assign accept     = cmd_valid && (state_q == IDLE);
  assign eff_period = (cmd_period == '0) ? PERIOD_W'(PERIOD_MIN) : cmd_period;
  assign load       = accept && (cmd_steps != '0);
  assign div_period = load ? eff_period : period_q;
  // With period 1 the first edge lands on the accept edge, so use the fresh command fields.
  assign cur_dir    = accept ? cmd_dir : dir_q;
  assign cur_rem    = accept ? cmd_steps : rem_q;

  qenc_tick_div #(.PERIOD_W(PERIOD_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .en_i     (state_q == RUN),
    .period_i (div_period),
    .tick_o   (tick)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    period_d = period_q;
    done_d   = 1'b0;
    if (accept) begin
      dir_d    = cmd_dir;
      period_d = eff_period;
      rem_d    = cmd_steps;
      if (cmd_steps == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
    if (tick) begin
      phase_d = next_phase(phase_q, cur_dir);
      pos_d   = cur_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      rem_d   = cur_rem - STEP_W'(1);
      if (cur_rem == STEP_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= 2'b00;
      pos_q    <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      period_q <= PERIOD_W'(PERIOD_MIN);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

`ifdef QENC_BOUNCE_EN
  logic [1:0]          enc_q, enc_d;
  logic [1:0]          mask_q, mask_d;
  logic [1:0]          stage_q, stage_d;
  logic [PERIOD_W-1:0] cur_period;

  assign cur_period = accept ? eff_period : period_q;

  // Stage 1 flips the changed line back for one cycle, stage 2 restores it.
  always_comb begin
    enc_d   = enc_q;
    mask_d  = mask_q;
    stage_d = 2'd0;
    case (stage_q)
      2'd1: begin
        enc_d   = enc_q ^ mask_q;
        stage_d = 2'd2;
      end
      2'd2: enc_d = phase_q;
      default: ;
    endcase
    if (tick) begin
      enc_d   = phase_d;
      mask_d  = phase_d ^ phase_q;
      stage_d = (bounce_en && (cur_period >= PERIOD_W'(BOUNCE_MIN_PERIOD))) ? 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_q   <= 2'b00;
      mask_q  <= 2'b00;
      stage_q <= 2'd0;
    end else begin
      enc_q   <= enc_d;
      mask_q  <= mask_d;
      stage_q <= stage_d;
    end
  end

  assign {enc_a, enc_b} = enc_q;
`else
  logic unused_bounce;
  assign unused_bounce  = bounce_en;
  assign {enc_a, enc_b} = phase_q;
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign position    = pos_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_quadrature_encoder_tx.sv
// Self-checking bench for quadrature_encoder_tx: vector table, scoreboard of expected
// edges (cycle, A/B, position) and done pulses, plus hand-written corner sequences.
module tb_quadrature_encoder_tx;
  import qenc_pkg::*;

  localparam int STEP_W   = 8;
  localparam int PERIOD_W = 16;
  localparam int POS_W    = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [STEP_W-1:0]   cmd_steps;
  logic                cmd_dir;
  logic [PERIOD_W-1:0] cmd_period;
  logic                bounce_en;
  logic                enc_a;
  logic                enc_b;
  logic                busy;
  logic                done;
  logic [POS_W-1:0]    position;
  qenc_state_e         dbg_state;

  quadrature_encoder_tx #(
    .STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .POS_W(POS_W)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .bounce_en(bounce_en), .enc_a(enc_a), .enc_b(enc_b), .busy(busy),
    .done(done), .position(position), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: edge word is {cycle[31:0], A, B, position[15:0]}.
  logic [49:0] exp_q[$];
  logic [31:0] done_q[$];

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  logic [17:0] prev_obs;

  // Reference model: CW order of (A,B) around the ring.
  logic [1:0]  ring[4];
  int          m_idx = 0;
  logic [15:0] m_pos = '0;

  typedef struct {
    int          steps;
    bit          dir;
    int          per;
    logic [1:0]  exp_ab;
    logic [15:0] exp_pos;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; sample at the falling edge and score any output change.
  task automatic tick();
    logic [17:0] cur;
    logic [49:0] e;
    @(negedge clk);
    cyc++;
    cur = {enc_a, enc_b, position};
    if (mon_en) begin
      if (cur != prev_obs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_edge", longint'(cur), longint'(prev_obs));
        end else begin
          e = exp_q.pop_front();
          check("edge", longint'({cyc[31:0], cur}), longint'(e));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_cycle", longint'(cyc), longint'(done_q.pop_front()));
        end
      end
    end
    prev_obs = cur;
  endtask

  task automatic model_step(input bit dir);
    m_idx = dir ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
    m_pos = dir ? m_pos + 16'd1 : m_pos - 16'd1;
  endtask

  task automatic send(input int steps, input bit dir, input int per);
    int p;
    int n;
    int k;
    k = 0;
    while (!cmd_ready && k < 3000) begin
      tick();
      k++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_steps  = STEP_W'(steps);
    cmd_dir    = dir;
    cmd_period = PERIOD_W'(per);
    cmd_valid  = 1'b1;
    p = (per == 0) ? 1 : per;
    n = cyc + 1;
    for (int i = 1; i <= steps; i++) begin
      model_step(dir);
      exp_q.push_back({32'(n + i * p - 1), ring[m_idx], m_pos});
    end
    done_q.push_back((steps == 0) ? 32'(n) : 32'(n + steps * p - 1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && k < 5000) begin
      tick();
      k++;
    end
    if (k >= 5000) check("idle_timeout", 0, 1);
    tick();
    tick();
  endtask

  initial begin
    int n;
    int k;
    ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;
    vecs[0] = '{4, 1'b1, 3, 2'b00, 16'd4};
    vecs[1] = '{2, 1'b0, 0, 2'b11, 16'd2};
    vecs[2] = '{0, 1'b1, 5, 2'b11, 16'd2};
    vecs[3] = '{5, 1'b1, 1, 2'b01, 16'd7};
    vecs[4] = '{3, 1'b0, 2, 2'b00, 16'd4};
    vecs[5] = '{6, 1'b0, 4, 2'b11, 16'hFFFE};

    reset = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
    cmd_period = '0; bounce_en = 1'b0; prev_obs = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ab", longint'({enc_a, enc_b}), 0);
    check("rst_pos", longint'(position), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_ready", longint'(cmd_ready), 1);
    mon_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].steps, vecs[v].dir, vecs[v].per);
      if (vecs[v].steps == 0) begin
        check("zero_ready", longint'(cmd_ready), 1);
        check("zero_busy", longint'(busy), 0);
      end
      wait_idle();
      check("vec_ab", longint'({enc_a, enc_b}), longint'(vecs[v].exp_ab));
      check("vec_pos", longint'(position), longint'(vecs[v].exp_pos));
    end

    // Back-to-back: second command offered on the done cycle keeps 5-cycle spacing.
    send(3, 1'b1, 5);
    check("b2b_busy", longint'(busy), 1);
    send(3, 1'b1, 5);
    wait_idle();

    // cmd_valid during RUN must be ignored.
    send(6, 1'b0, 4);
    tick(); tick();
    check("run_busy", longint'(busy), 1);
    check("run_ready", longint'(cmd_ready), 0);
    cmd_steps = 8'd50; cmd_dir = 1'b1; cmd_period = 16'd1; cmd_valid = 1'b1;
    repeat (4) tick();
    cmd_valid = 1'b0;
    wait_idle();

    for (int r = 0; r < 4; r++) begin
      send(int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
    wait_idle();

    // Reset after 2 of 8 edges.
    send(8, 1'b1, 3);
    k = 0;
    while (exp_q.size() > 6 && k < 100) begin
      tick();
      k++;
    end
    if (exp_q.size() > 6) check("reset_wait_timeout", 0, 1);
    reset = 1'b1;
    mon_en = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_ab", longint'({enc_a, enc_b}), 0);
    check("mid_rst_pos", longint'(position), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_done", longint'(done), 0);
    check("mid_rst_ready", longint'(cmd_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_done", longint'(done), 0);
    end
    exp_q.delete();
    done_q.delete();
    m_idx = 0;
    m_pos = '0;
    mon_en = 1'b1;

    bounce_en = 1'b1;
`ifdef QENC_BOUNCE_EN
    mon_en = 1'b0;
    cmd_steps = 8'd1; cmd_dir = 1'b1; cmd_period = 16'd6; cmd_valid = 1'b1;
    n = cyc + 1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("bounce_a", longint'(enc_a), (cyc >= n + 5 && cyc != n + 6) ? 1 : 0);
      check("bounce_b", longint'(enc_b), 0);
      tick();
    end
    model_step(1'b1);
    check("bounce_pos", longint'(position), longint'(m_pos));
    mon_en = 1'b1;
`else
    send(1, 1'b1, 6);
    wait_idle();
`endif
    send(1, 1'b1, 3);
    wait_idle();
    check("final_ab", longint'({enc_a, enc_b}), longint'(ring[m_idx]));
    check("final_pos", longint'(position), longint'(m_pos));
    bounce_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
